// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Pipelined RV32 instruction decode stage.
//
// Fetch pushes raw instruction words and their PCs into a small circular
// instruction queue. The queue head is decoded combinationally and captured
// into a registered decode packet whenever the output register is free.
// The packet is then held stable until execute accepts it.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   flush             drop everything queued and the held output packet
//   in_valid/ready    fetch handshake (in_ready never looks at out_ready)
//   in_instr, in_pc   raw instruction word and its PC
//   out_valid/ready   execute handshake
//   out_*             decode packet: fields, immediate, format, flags and
//                     integer/FP register-file enables
//   count             queue occupancy (the output register is not counted)
//
// Parameters
//   XLEN       immediate/PC width, >= 32
//   DEPTH      queue entries, power of two, >= 2
//   ENABLE_FP  0 makes LOAD-FP/STORE-FP/OP-FP decode as illegal
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int ENABLE_FP = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [XLEN-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [6:0]                   out_opcode,
  output logic [2:0]                   out_funct3,
  output logic [6:0]                   out_funct7,
  output logic                         out_funct7_valid,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [XLEN-1:0]              out_imm,
  output logic [2:0]                   out_fmt,
  output logic                         out_branch,
  output logic                         out_illegal,
  output logic                         out_irf_re1,
  output logic                         out_irf_re2,
  output logic                         out_irf_we,
  output logic                         out_frf_re1,
  output logic                         out_frf_re2,
  output logic                         out_frf_we,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam bit FP_ON = (ENABLE_FP != 0);

  // Opcode map
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // Format codes
  localparam logic [2:0] FMT_R = 3'b000;
  localparam logic [2:0] FMT_I = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_J = 3'b101;
  localparam logic [2:0] FMT_X = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            funct7_valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            branch;
    logic            illegal;
    logic            irf_re1;
    logic            irf_re2;
    logic            irf_we;
    logic            frf_re1;
    logic            frf_re2;
    logic            frf_we;
  } pkt_t;

  // ------------------------------------------------------------------------
  // Instruction queue state
  // ------------------------------------------------------------------------
  logic [31:0]     mem_instr_q [DEPTH];
  logic [31:0]     mem_instr_d [DEPTH];
  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [XLEN-1:0] mem_pc_d    [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Output register state
  logic            out_valid_q, out_valid_d;
  pkt_t            pkt_q, pkt_d;

  logic            push, pop, out_free;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;

  // Decode of the queue head
  pkt_t            dec;
  logic [2:0]      fmt;
  logic            wb_int;
  logic [31:0]     imm32;

  // in_ready is gated by rst_n so fetch sees back-pressure during reset
  assign in_ready = (count_q < DEPTH_C) && rst_n;
  assign push     = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;
  assign pop      = (count_q != '0) && out_free;

  assign head_instr = mem_instr_q[rd_ptr_q];
  assign head_pc    = mem_pc_q[rd_ptr_q];

  // ------------------------------------------------------------------------
  // Decode. Every mapped opcode already ends in 2'b11, so a word whose low
  // bits differ falls through to the default arm and comes out illegal.
  // ------------------------------------------------------------------------
  always_comb begin
    dec        = '0;
    dec.pc     = head_pc;
    dec.opcode = head_instr[6:0];
    fmt        = FMT_X;
    wb_int     = 1'b0;
    imm32      = '0;

    case (head_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        fmt         = FMT_I;
        dec.irf_re1 = 1'b1;
        wb_int      = 1'b1;
      end
      OPC_LOAD_FP: if (FP_ON) begin
        // FP load: integer base register, FP destination
        fmt         = FMT_I;
        dec.irf_re1 = 1'b1;
        dec.frf_we  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt    = FMT_U;
        wb_int = 1'b1;
      end
      OPC_STORE: begin
        fmt         = FMT_S;
        dec.irf_re1 = 1'b1;
        dec.irf_re2 = 1'b1;
      end
      OPC_STORE_FP: if (FP_ON) begin
        fmt         = FMT_S;
        dec.irf_re1 = 1'b1;
        dec.frf_re2 = 1'b1;
      end
      OPC_OP: begin
        fmt         = FMT_R;
        dec.irf_re1 = 1'b1;
        dec.irf_re2 = 1'b1;
        wb_int      = 1'b1;
      end
      OPC_OP_FP: if (FP_ON) begin
        fmt         = FMT_R;
        dec.frf_re1 = 1'b1;
        dec.frf_re2 = 1'b1;
        dec.frf_we  = 1'b1;
      end
      OPC_BRANCH: begin
        fmt         = FMT_B;
        dec.irf_re1 = 1'b1;
        dec.irf_re2 = 1'b1;
        dec.branch  = 1'b1;
      end
      OPC_JAL: begin
        fmt    = FMT_J;
        wb_int = 1'b1;
      end
      default: ;
    endcase

    dec.fmt     = fmt;
    dec.illegal = (fmt == FMT_X);
    // x0 writes are dropped at decode so execute never sees them
    dec.irf_we  = wb_int && (head_instr[11:7] != 5'd0);

    // Field extraction; an illegal word matches none of these formats
    if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B) begin
      dec.rs1    = head_instr[19:15];
      dec.funct3 = head_instr[14:12];
    end
    if (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B)
      dec.rs2 = head_instr[24:20];
    if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J)
      dec.rd = head_instr[11:7];
    if (fmt == FMT_R) begin
      dec.funct7       = head_instr[31:25];
      dec.funct7_valid = 1'b1;
    end

    case (fmt)
      FMT_I: imm32 = {{20{head_instr[31]}}, head_instr[31:20]};
      FMT_S: imm32 = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      FMT_B: imm32 = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                      head_instr[30:25], head_instr[11:8], 1'b0};
      FMT_U: imm32 = {head_instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                      head_instr[20], head_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  // ------------------------------------------------------------------------
  // Queue and output-register next state
  // ------------------------------------------------------------------------
  always_comb begin
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    pkt_d       = pkt_q;

    if (flush) begin
      // Everything in flight is dropped, including a same-cycle push
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_instr_d[wr_ptr_q] = in_instr;
        mem_pc_d[wr_ptr_q]    = in_pc;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        pkt_d       = dec;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array carries no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    mem_instr_q <= mem_instr_d;
    mem_pc_q    <= mem_pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      pkt_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      pkt_q       <= pkt_d;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign count            = count_q;
  assign out_valid        = out_valid_q;
  assign out_pc           = pkt_q.pc;
  assign out_opcode       = pkt_q.opcode;
  assign out_funct3       = pkt_q.funct3;
  assign out_funct7       = pkt_q.funct7;
  assign out_funct7_valid = pkt_q.funct7_valid;
  assign out_rs1          = pkt_q.rs1;
  assign out_rs2          = pkt_q.rs2;
  assign out_rd           = pkt_q.rd;
  assign out_imm          = pkt_q.imm;
  assign out_fmt          = pkt_q.fmt;
  assign out_branch       = pkt_q.branch;
  assign out_illegal      = pkt_q.illegal;
  assign out_irf_re1      = pkt_q.irf_re1;
  assign out_irf_re2      = pkt_q.irf_re2;
  assign out_irf_we       = pkt_q.irf_we;
  assign out_frf_re1      = pkt_q.frf_re1;
  assign out_frf_re2      = pkt_q.frf_re2;
  assign out_frf_we       = pkt_q.frf_we;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed bench for decode_stage. A reference model (instruction queue plus
// one output slot, with decode computed from the ISA field definitions)
// is compared against the DUT on every falling edge. Directed sequences add
// hand-computed literal expectations. A second instance with ENABLE_FP=0
// covers FP opcodes decoding as illegal.
// ---------------------------------------------------------------------------
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        f7v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        branch;
    logic        illegal;
    logic        irf_re1;
    logic        irf_re2;
    logic        irf_we;
    logic        frf_re1;
    logic        frf_re2;
    logic        frf_we;
  } pkt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_fmt, count;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic out_funct7_valid, out_branch, out_illegal;
  logic out_irf_re1, out_irf_re2, out_irf_we, out_frf_re1, out_frf_re2, out_frf_we;

  // Second instance, FP disabled
  logic in_valid2, in_ready2, out_valid2;
  logic [31:0] in_instr2, in_pc2, out_pc2, out_imm2;
  logic [6:0]  out_opcode2, out_funct72;
  logic [2:0]  out_funct32, out_fmt2, count2;
  logic [4:0]  out_rs12, out_rs22, out_rd2;
  logic out_funct7_valid2, out_branch2, out_illegal2;
  logic out_irf_re12, out_irf_re22, out_irf_we2, out_frf_re12, out_frf_re22, out_frf_we2;

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_FP(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_funct7_valid(out_funct7_valid), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_fmt(out_fmt), .out_branch(out_branch),
    .out_illegal(out_illegal), .out_irf_re1(out_irf_re1), .out_irf_re2(out_irf_re2),
    .out_irf_we(out_irf_we), .out_frf_re1(out_frf_re1), .out_frf_re2(out_frf_re2),
    .out_frf_we(out_frf_we), .count(count)
  );

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_FP(0)) dut_nofp (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_instr(in_instr2), .in_pc(in_pc2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_pc(out_pc2),
    .out_opcode(out_opcode2), .out_funct3(out_funct32), .out_funct7(out_funct72),
    .out_funct7_valid(out_funct7_valid2), .out_rs1(out_rs12), .out_rs2(out_rs22),
    .out_rd(out_rd2), .out_imm(out_imm2), .out_fmt(out_fmt2), .out_branch(out_branch2),
    .out_illegal(out_illegal2), .out_irf_re1(out_irf_re12), .out_irf_re2(out_irf_re22),
    .out_irf_we(out_irf_we2), .out_frf_re1(out_frf_re12), .out_frf_re2(out_frf_re22),
    .out_frf_we(out_frf_we2), .count(count2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sign-extend the low 'bits' of v to 32 bits arithmetically
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    longint x;
    x = longint'(v);
    if (v[bits-1]) x = x - (longint'(1) << bits);
    return 32'(x);
  endfunction

  function automatic pkt_t ref_decode(input logic [31:0] w, input bit fp);
    pkt_t p;
    int   f;
    bit   r1, r2, wi, fr1, fr2, wf;
    p = '0;
    p.opcode = w[6:0];
    f = -1;
    {r1, r2, wi, fr1, fr2, wf} = '0;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin f = 1; r1 = 1; wi = 1; end
      7'b0000111: if (fp) begin f = 1; r1 = 1; wf = 1; end
      7'b0110111, 7'b0010111: begin f = 4; wi = 1; end
      7'b0100011: begin f = 2; r1 = 1; r2 = 1; end
      7'b0100111: if (fp) begin f = 2; r1 = 1; fr2 = 1; end
      7'b0110011: begin f = 0; r1 = 1; r2 = 1; wi = 1; end
      7'b1010011: if (fp) begin f = 0; fr1 = 1; fr2 = 1; wf = 1; end
      7'b1100011: begin f = 3; r1 = 1; r2 = 1; p.branch = 1; end
      7'b1101111: begin f = 5; wi = 1; end
      default: ;
    endcase
    if (f < 0) begin
      p.illegal = 1'b1;
      p.fmt     = 3'b111;
      return p;
    end
    p.fmt = f[2:0];
    if (f != 4 && f != 5) begin p.rs1 = w[19:15]; p.funct3 = w[14:12]; end
    if (f == 0 || f == 2 || f == 3) p.rs2 = w[24:20];
    if (f != 2 && f != 3) p.rd = w[11:7];
    if (f == 0) begin p.funct7 = w[31:25]; p.f7v = 1'b1; end
    case (f)
      1: p.imm = sx({20'b0, w[31:20]}, 12);
      2: p.imm = sx({20'b0, w[31:25], w[11:7]}, 12);
      3: p.imm = sx({19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
      4: p.imm = {w[31:12], 12'h000};
      5: p.imm = sx({11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
      default: p.imm = '0;
    endcase
    p.irf_re1 = r1; p.irf_re2 = r2; p.irf_we = wi && (w[11:7] != 5'd0);
    p.frf_re1 = fr1; p.frf_re2 = fr2; p.frf_we = wf;
    return p;
  endfunction

  // ------------------------------------------------------------------------
  // Reference model: pending queue plus one output slot, compared per cycle
  // ------------------------------------------------------------------------
  logic [63:0] mq[$];
  bit          s_valid = 0;
  logic [31:0] s_instr, s_pc;
  bit          mon_en = 0;

  always @(negedge clk) begin
    pkt_t act, exp;
    int   sz;
    act = '{pc:out_pc, opcode:out_opcode, funct3:out_funct3, funct7:out_funct7,
            f7v:out_funct7_valid, rs1:out_rs1, rs2:out_rs2, rd:out_rd, imm:out_imm,
            fmt:out_fmt, branch:out_branch, illegal:out_illegal,
            irf_re1:out_irf_re1, irf_re2:out_irf_re2, irf_we:out_irf_we,
            frf_re1:out_frf_re1, frf_re2:out_frf_re2, frf_we:out_frf_we};
    sz = mq.size();
    if (mon_en) begin
      chk("out_valid", out_valid, s_valid);
      chk("count", count, sz);
      chk("in_ready", in_ready, (sz < DEPTH) && rst_n);
      if (s_valid) begin
        exp = ref_decode(s_instr, 1'b1);
        exp.pc = s_pc;
        chk("pkt", act, exp);
      end
    end
    if (!rst_n || flush) begin
      mq.delete();
      s_valid = 0;
    end else begin
      if (sz > 0 && (!s_valid || out_ready)) begin
        {s_pc, s_instr} = mq.pop_front();
        s_valid = 1;
      end else if (out_ready) begin
        s_valid = 0;
      end
      if (in_valid && sz < DEPTH) mq.push_back({in_pc, in_instr});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 1;
    in_valid2 = 0; in_instr2 = 0; in_pc2 = 0;
    step();
    mon_en = 1;
    step();
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    step();
    rst_n = 1;
    @(negedge clk);
    chk("in_ready_release", in_ready, 1);

    // addi x5,x1,-1
    step(); drive(32'hFFF08293, 32'h100);
    step(); in_valid = 0;
    @(negedge clk);
    chk("addi_latency_valid", out_valid, 0);
    chk("addi_latency_count", count, 1);
    step();
    @(negedge clk);
    chk("addi_valid", out_valid, 1);
    chk("addi_fields", {out_fmt, out_rd, out_rs1, out_rs2}, {3'b001, 5'd5, 5'd1, 5'd0});
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_en", {out_irf_re1, out_irf_re2, out_irf_we}, 3'b101);

    // beq x1,x2,-4 then lui x10,0x12345
    step(); drive(32'hFE208EE3, 32'h104);
    step(); drive(32'h12345537, 32'h108);
    step(); in_valid = 0;
    @(negedge clk);
    chk("beq_branch", {out_valid, out_branch}, 2'b11);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_rd_we", {out_rd, out_irf_we}, 6'd0);
    step();
    @(negedge clk);
    chk("lui_fmt", out_fmt, 3'b100);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_rs1_en", {out_rs1, out_irf_re1, out_irf_we}, {5'd0, 1'b0, 1'b1});
    chk("lui_rd", out_rd, 5'd10);

    // Stall: 5 accepted, sixth held off
    step(); out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h00000093 | (32'(i + 1) << 20), 32'h200 + 32'(4 * i));
      step();
    end
    drive(32'h00600093, 32'h214);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    repeat (3) step();
    @(negedge clk);
    chk("full_count", count, 4);
    chk("full_hold_pc", {out_valid, out_pc}, {1'b1, 32'h200});
    step(); in_valid = 0; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_order", {out_valid, out_pc}, {1'b1, 32'h200 + 32'(4 * i)});
      step();
    end
    @(negedge clk);
    chk("drain_empty", out_valid, 0);

    // Flush with 3 queued and a packet held
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h00100093, 32'h300 + 32'(4 * i));
      step();
    end
    drive(32'h00700093, 32'h3F0);
    flush = 1;
    @(negedge clk);
    chk("preflush", {out_valid, count}, {1'b1, 3'd3});
    step(); flush = 0; drive(32'h00000013, 32'h400); out_ready = 1;
    @(negedge clk);
    chk("postflush", {out_valid, count}, {1'b0, 3'd0});
    step(); in_valid = 0;
    @(negedge clk);
    chk("postflush_push", {out_valid, count}, {1'b0, 3'd1});
    step();
    @(negedge clk);
    chk("postflush_out", {out_valid, out_pc, out_opcode}, {1'b1, 32'h400, 7'h13});
    step();
    @(negedge clk);
    chk("flush_drop", out_valid, 0);

    // Illegal word and fadd.s on both instances
    step(); drive(32'h00000000, 32'h500);
    step(); drive(32'h003100D3, 32'h504);
    in_valid2 = 1; in_instr2 = 32'h003100D3; in_pc2 = 32'h504;
    step(); in_valid = 0; in_valid2 = 0;
    @(negedge clk);
    chk("illegal_flag", {out_valid, out_illegal, out_fmt}, {1'b1, 1'b1, 3'b111});
    chk("illegal_en", {out_irf_re1, out_irf_re2, out_irf_we, out_frf_re1, out_frf_re2, out_frf_we}, 6'd0);
    step();
    @(negedge clk);
    chk("fadd_frf", {out_frf_re1, out_frf_re2, out_frf_we}, 3'b111);
    chk("fadd_irf", {out_irf_re1, out_irf_re2, out_irf_we}, 3'b000);
    chk("fadd_fields", {out_fmt, out_rd, out_rs1, out_rs2, out_funct7_valid}, {3'b000, 5'd1, 5'd2, 5'd3, 1'b1});
    chk("nofp_illegal", {out_valid2, out_illegal2, out_fmt2, out_opcode2}, {1'b1, 1'b1, 3'b111, 7'h53});
    chk("nofp_zero", {out_frf_re12, out_frf_re22, out_frf_we2, out_rs12, out_imm2}, '0);

    // Reset mid-stream with a full queue
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h00A00513 + 32'(i << 20), 32'h600 + 32'(4 * i));
      step();
    end
    drive(32'h00800093, 32'h700);
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 0);
    step(); rst_n = 1; in_valid = 0;
    @(negedge clk);
    chk("rst_mid_state", {out_valid, count, in_ready}, {1'b0, 3'd0, 1'b1});
    chk("rst_mid_pkt", {out_pc, out_opcode, out_funct3, out_funct7, out_funct7_valid,
                        out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_branch, out_illegal,
                        out_irf_re1, out_irf_re2, out_irf_we, out_frf_re1, out_frf_re2, out_frf_we}, '0);
    step(); out_ready = 1; drive(32'h00C58633, 32'h800);
    step(); drive(32'h0000006F, 32'h804);
    step(); in_valid = 0;
    @(negedge clk);
    chk("resume_add", {out_valid, out_pc, out_rd}, {1'b1, 32'h800, 5'd12});
    step();
    @(negedge clk);
    chk("resume_jal", {out_valid, out_fmt, out_irf_we}, {1'b1, 3'b101, 1'b0});
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined RV32 instruction decode stage with an input instruction queue and valid/ready handshakes on both sides. Fetch pushes raw instruction words and PCs in. The block classifies each word by format, extracts register indices and function fields, and builds the sign-extended immediate. It also generates the integer and FP register-file enables and flags branches and illegal encodings, then hands a registered decode packet to the execute stage. It replaces the combinational, stage-gated control decode.

## Interface
- XLEN, 32: immediate/PC width; immediates sign-extended to XLEN (XLEN ≥ 32).
- DEPTH, 4: instruction queue entries; power of two, ≥ 2.
- ENABLE_FP, 1: 1 = decode LOAD-FP/STORE-FP/OP-FP; 0 = treat them as illegal.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all queued and output-held instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decode packet valid.
- out_ready  in  1  execute accepts packet.
- out_pc  out  XLEN  PC of the packet.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12]; 0 for U/J.
- out_funct7  out  7  instr[31:25] when out_funct7_valid, else 0.
- out_funct7_valid  out  1  1 only for R format.
- out_rs1  out  5  instr[19:15]; 0 for U/J.
- out_rs2  out  5  instr[24:20]; 0 for I/U/J.
- out_rd  out  5  instr[11:7]; 0 for S/B.
- out_imm  out  XLEN  decoded immediate; 0 for R.
- out_fmt  out  3  format: R=000, I=001, S=010, B=011, U=100, J=101, unknown=111.
- out_branch  out  1  opcode 1100011.
- out_illegal  out  1  unrecognised encoding.
- out_irf_re1, out_irf_re2, out_irf_we  out  1 each  integer RF enables.
- out_frf_re1, out_frf_re2, out_frf_we  out  1 each  FP RF enables.
- count  out  $clog2(DEPTH+1)  queue occupancy (excludes the output register).

## Operation
- Opcode map:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, LOAD-FP 0000111.
  - U: LUI 0110111, AUIPC 0010111.
  - S: STORE 0100011, STORE-FP 0100111.
  - R: OP 0110011, OP-FP 1010011.
  - B: BRANCH 1100011.
  - J: JAL 1101111.
- Illegal: any other opcode, instr[1:0] ≠ 11, or an FP opcode with ENABLE_FP=0. Result: out_illegal=1, fmt=111, all enables 0, all fields and imm 0, opcode still reported.
- Immediates, all sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Enables:
  - irf_re1: all legal formats except U/J and OP-FP (LOAD-FP/STORE-FP base uses the IRF).
  - irf_re2: OP, STORE, BRANCH.
  - frf_re1: OP-FP.
  - frf_re2: OP-FP, STORE-FP.
  - irf_we: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd ≠ 0.
  - frf_we: OP-FP, LOAD-FP.
- Queue: circular buffer with wrapping read/write pointers.
  - Push when in_valid && in_ready.
  - Pop when the queue is non-empty and the output register is free (!out_valid || out_ready).
  - The popped word is decoded combinationally from the queue head and registered into the output stage in the same edge.
- Output register holds the packet stable while out_valid && !out_ready.

## Timing
- in_ready = (count < DEPTH) && rst_n. It does not depend on out_ready, so there is no combinational in→out path.
- Latency: word pushed at edge N → out_valid after edge N+1, provided the output register is free. Throughput is 1 instruction/cycle.
- Simultaneous push and pop: count unchanged. Pushing into a full queue is impossible because in_ready=0.
- Capacity: DEPTH queued plus 1 in the output register (DEPTH+1 total) while stalled.
- flush=1 at an edge:
  - count→0, pointers→0, out_valid→0.
  - A concurrent push is dropped.
  - The first instruction pushed after the flush edge is the next one output.
- Reset (rst_n=0 at an edge) overrides flush and applies mid-operation. After reset:
  - count=0, out_valid=0.
  - All packet outputs are 0.
  - in_ready=0 while rst_n is low and 1 on the first cycle after release.
- Ordering is strictly FIFO; no instruction is dropped or duplicated except by flush or reset.

## Test plan
- Push 0xFFF08293 (addi x5,x1,-1) → fmt=001, rd=5, rs1=1, rs2=0, imm=0xFFFFFFFF, irf_re1=1, irf_re2=0, irf_we=1, out_valid one edge after the push.
- Push 0xFE208EE3 (beq x1,x2,-4), then 0x12345537 (lui x10,0x12345) → beq packet: branch=1, imm=0xFFFFFFFC, rd=0, irf_we=0. lui packet: fmt=100, imm=0x12345000, rs1=0, irf_re1=0, irf_we=1.
- Hold out_ready=0 with DEPTH=4 and stream 6 instructions → 5 accepted, in_ready=0 with count=4, output packet stable. Then out_ready=1 → all 5 delivered in order on consecutive cycles.
- Assert flush with 3 queued and out_valid=1 → next cycle out_valid=0, count=0. A fresh push of 0x00000013 emerges next. A push coincident with the flush is never output.
- Push 0x00000000 → out_illegal=1, fmt=111, all enables 0. Push 0x003100D3 (fadd.s f1,f2,f3):
  - ENABLE_FP=1 → frf_re1=frf_re2=frf_we=1, irf_* = 0.
  - ENABLE_FP=0 → illegal.
- Drop rst_n for one cycle mid-stream with a full queue → count=0, out_valid=0, all packet outputs 0. Traffic resumes correctly after release.
